// File: rtl/uart_core.sv
// uart_core: parametrised full-duplex UART with a 16x oversampled receiver
// and a first-word-fall-through RX FIFO that has sticky error flags.
//
// Ports
//   clk, rst_n      system clock, asynchronous active-low reset
//   tx_start        send request, accepted only while tx_busy is low
//   tx_data         word to send, latched on acceptance
//   tx_busy         a frame is being transmitted
//   txd             registered serial output, idles high
//   rxd             asynchronous serial input
//   rx_data         FIFO head (valid while rx_valid is high)
//   rx_valid        FIFO not empty
//   rx_read         pop the FIFO head, ignored when empty
//   rx_count        number of FIFO entries
//   rx_frame_err    sticky: first stop bit sampled low
//   rx_parity_err   sticky: parity mismatch on a frame with a good stop bit
//   rx_overrun      sticky: good frame dropped because the FIFO was full
//   err_clear       clears the three sticky flags (a new error wins)
module uart_core #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          tx_start,
  input  logic [DATA_BITS-1:0]          tx_data,
  output logic                          tx_busy,
  output logic                          txd,
  input  logic                          rxd,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_valid,
  input  logic                          rx_read,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  output logic                          rx_frame_err,
  output logic                          rx_parity_err,
  output logic                          rx_overrun,
  input  logic                          err_clear
);

  // Rounded divider from the clock to the 16x oversampling tick.
  localparam longint DIV_L   = (longint'(CLK_FREQ) + 8 * longint'(BAUD)) / (16 * longint'(BAUD));
  localparam int     DIV     = int'(DIV_L);
  localparam longint GEN_F   = DIV_L * 16 * longint'(BAUD);
  localparam longint GEN_ERR = (GEN_F > longint'(CLK_FREQ)) ? GEN_F - longint'(CLK_FREQ)
                                                            : longint'(CLK_FREQ) - GEN_F;
  localparam int CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = PW + 1;

  localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
  localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic [4:0]    STOP_LAST = 5'(STOP_BITS * 16 - 1);
  localparam logic          ODD       = (PARITY == 2);

  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
    $error("uart_core: DATA_BITS must be in 5..8");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_core: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_core: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
    $error("uart_core: FIFO_DEPTH must be a power of 2 and at least 2");
  end
  if (DIV < 1 || GEN_ERR * 50 >= longint'(CLK_FREQ)) begin : g_bad_baud
    $error("uart_core: baud generation error of the rounded divider is 2%% or more");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_e;

  // ---------------------------------------------------------------------
  // Tick generator, shared by TX and RX
  // ---------------------------------------------------------------------
  logic [CW-1:0] div_q;
  logic          tick;

  assign tick = (div_q == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
    end else if (tick) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Transmitter
  // ---------------------------------------------------------------------
  state_e               tx_state_q;
  logic [4:0]           tx_tcnt_q;
  logic [2:0]           tx_bit_q;
  logic [DATA_BITS-1:0] tx_shift_q;
  logic                 tx_par_q;
  logic                 txd_q;
  logic                 tx_busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= ST_IDLE;
      tx_tcnt_q  <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      txd_q      <= 1'b1;
      tx_busy_q  <= 1'b0;
    end else begin
      case (tx_state_q)
        ST_IDLE: begin
          if (tx_start) begin
            tx_shift_q <= tx_data;
            tx_par_q   <= (^tx_data) ^ ODD;
            tx_tcnt_q  <= '0;
            tx_state_q <= ST_START;
            txd_q      <= 1'b0;
            tx_busy_q  <= 1'b1;
          end
        end
        ST_START: begin
          if (tick) begin
            if (tx_tcnt_q == 5'd15) begin
              tx_tcnt_q  <= '0;
              tx_bit_q   <= '0;
              tx_state_q <= ST_DATA;
              txd_q      <= tx_shift_q[0];
            end else begin
              tx_tcnt_q <= tx_tcnt_q + 5'd1;
            end
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (tx_tcnt_q == 5'd15) begin
              tx_tcnt_q  <= '0;
              tx_shift_q <= tx_shift_q >> 1;
              if (tx_bit_q == LAST_BIT) begin
                if (PARITY != 0) begin
                  tx_state_q <= ST_PARITY;
                  txd_q      <= tx_par_q;
                end else begin
                  tx_state_q <= ST_STOP;
                  txd_q      <= 1'b1;
                end
              end else begin
                tx_bit_q <= tx_bit_q + 3'd1;
                // Next bit is the one about to become bit 0 after the shift.
                txd_q    <= tx_shift_q[1];
              end
            end else begin
              tx_tcnt_q <= tx_tcnt_q + 5'd1;
            end
          end
        end
        ST_PARITY: begin
          if (tick) begin
            if (tx_tcnt_q == 5'd15) begin
              tx_tcnt_q  <= '0;
              tx_state_q <= ST_STOP;
              txd_q      <= 1'b1;
            end else begin
              tx_tcnt_q <= tx_tcnt_q + 5'd1;
            end
          end
        end
        ST_STOP: begin
          if (tick) begin
            if (tx_tcnt_q == STOP_LAST) begin
              tx_tcnt_q  <= '0;
              tx_state_q <= ST_IDLE;
              tx_busy_q  <= 1'b0;
            end else begin
              tx_tcnt_q <= tx_tcnt_q + 5'd1;
            end
          end
        end
        default: begin
          tx_state_q <= ST_IDLE;
          txd_q      <= 1'b1;
          tx_busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign txd     = txd_q;
  assign tx_busy = tx_busy_q;

  // ---------------------------------------------------------------------
  // Receiver: synchroniser and oversampling FSM
  // ---------------------------------------------------------------------
  logic rx_s1_q;
  logic rx_s2_q;
  logic rx_line;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
    end else begin
      rx_s1_q <= rxd;
      rx_s2_q <= rx_s1_q;
    end
  end

  assign rx_line = rx_s2_q;

  state_e               rx_state_q;
  logic [3:0]           rx_cnt_q;
  logic [2:0]           rx_bit_q;
  logic [DATA_BITS-1:0] rx_shift_q;
  logic                 rx_par_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q <= ST_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_par_q   <= 1'b0;
    end else begin
      case (rx_state_q)
        ST_IDLE: begin
          if (tick && !rx_line) begin
            rx_cnt_q   <= '0;
            rx_state_q <= ST_START;
          end
        end
        ST_START: begin
          if (tick) begin
            // Mid-start check: a line that has gone high again is a glitch.
            if (rx_cnt_q == 4'd7) begin
              rx_cnt_q <= '0;
              rx_bit_q <= '0;
              rx_state_q <= rx_line ? ST_IDLE : ST_DATA;
            end else begin
              rx_cnt_q <= rx_cnt_q + 4'd1;
            end
          end
        end
        ST_DATA: begin
          if (tick) begin
            rx_cnt_q <= rx_cnt_q + 4'd1;
            if (rx_cnt_q == 4'd15) begin
              rx_shift_q <= {rx_line, rx_shift_q[DATA_BITS-1:1]};
              if (rx_bit_q == LAST_BIT) begin
                rx_state_q <= (PARITY != 0) ? ST_PARITY : ST_STOP;
              end else begin
                rx_bit_q <= rx_bit_q + 3'd1;
              end
            end
          end
        end
        ST_PARITY: begin
          if (tick) begin
            rx_cnt_q <= rx_cnt_q + 4'd1;
            if (rx_cnt_q == 4'd15) begin
              rx_par_q   <= rx_line;
              rx_state_q <= ST_STOP;
            end
          end
        end
        ST_STOP: begin
          if (tick) begin
            rx_cnt_q <= rx_cnt_q + 4'd1;
            // Back to IDLE right at the stop sample so the next start bit
            // can be caught half a bit later.
            if (rx_cnt_q == 4'd15) begin
              rx_state_q <= ST_IDLE;
            end
          end
        end
        default: begin
          rx_state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Frame disposition
  // ---------------------------------------------------------------------
  logic rx_stop_done;
  logic rx_par_ok;
  logic rx_push_req;
  logic fifo_full;
  logic fifo_pop;
  logic fifo_push;
  logic set_frame_err;
  logic set_parity_err;
  logic set_overrun;

  logic [CNTW-1:0] count_q;
  logic [CNTW-1:0] count_d;
  logic [PW-1:0]   wr_ptr_q;
  logic [PW-1:0]   rd_ptr_q;

  assign rx_stop_done   = (rx_state_q == ST_STOP) && tick && (rx_cnt_q == 4'd15);
  assign rx_par_ok      = (PARITY == 0) || (rx_par_q == ((^rx_shift_q) ^ ODD));
  assign rx_push_req    = rx_stop_done && rx_line && rx_par_ok;
  assign set_frame_err  = rx_stop_done && !rx_line;
  assign set_parity_err = rx_stop_done && rx_line && !rx_par_ok;

  assign fifo_full   = (count_q == CNTW'(FIFO_DEPTH));
  assign fifo_pop    = rx_read && (count_q != '0);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign set_overrun = rx_push_req && fifo_full && !fifo_pop;
  assign fifo_push   = rx_push_req && (!fifo_full || fifo_pop);

  // ---------------------------------------------------------------------
  // RX FIFO (first-word-fall-through)
  // ---------------------------------------------------------------------
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];

  always_comb begin
    count_d = count_q;
    if (fifo_push && !fifo_pop) begin
      count_d = count_q + 1'b1;
    end else if (!fifo_push && fifo_pop) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (fifo_push) begin
        mem_q[wr_ptr_q] <= rx_shift_q;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (fifo_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_d;
    end
  end

  assign rx_data  = mem_q[rd_ptr_q];
  assign rx_valid = (count_q != '0);
  assign rx_count = count_q;

  // ---------------------------------------------------------------------
  // Sticky error flags (a new error beats err_clear)
  // ---------------------------------------------------------------------
  logic frame_err_q;
  logic parity_err_q;
  logic overrun_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      if (set_frame_err) begin
        frame_err_q <= 1'b1;
      end else if (err_clear) begin
        frame_err_q <= 1'b0;
      end
      if (set_parity_err) begin
        parity_err_q <= 1'b1;
      end else if (err_clear) begin
        parity_err_q <= 1'b0;
      end
      if (set_overrun) begin
        overrun_q <= 1'b1;
      end else if (err_clear) begin
        overrun_q <= 1'b0;
      end
    end
  end

  assign rx_frame_err  = frame_err_q;
  assign rx_parity_err = parity_err_q;
  assign rx_overrun    = overrun_q;

endmodule

// File: tb/tb_uart_core.sv
// Testbench for uart_core. Instance u_a uses the default 8N2 parameters at
// 50 MHz / 115200 (transmitter timing). Instance u_b uses 7 data bits, odd
// parity, one stop bit and a 4-clock tick so receive-side scenarios stay
// short; its rxd is either looped back from its own txd or driven directly.
module tb_uart_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  // Instance A: 8N2 at 27 clocks per tick
  logic       a_tx_start, a_tx_busy, a_txd, a_rxd;
  logic [7:0] a_tx_data, a_rx_data;
  logic       a_rx_valid, a_rx_read, a_err_clear;
  logic [2:0] a_rx_count;
  logic       a_fe, a_pe, a_ov;

  uart_core u_a (
    .clk(clk), .rst_n(rst_n),
    .tx_start(a_tx_start), .tx_data(a_tx_data), .tx_busy(a_tx_busy), .txd(a_txd),
    .rxd(a_rxd), .rx_data(a_rx_data), .rx_valid(a_rx_valid), .rx_read(a_rx_read),
    .rx_count(a_rx_count), .rx_frame_err(a_fe), .rx_parity_err(a_pe),
    .rx_overrun(a_ov), .err_clear(a_err_clear)
  );

  // Instance B: 7O1, 64 clocks per bit
  logic       b_tx_start, b_tx_busy, b_txd, b_rxd;
  logic [6:0] b_tx_data, b_rx_data;
  logic       b_rx_valid, b_rx_read, b_err_clear;
  logic [2:0] b_rx_count;
  logic       b_fe, b_pe, b_ov;
  logic       b_loop, b_drv;

  assign b_rxd = b_loop ? b_txd : b_drv;

  uart_core #(
    .CLK_FREQ(1600000), .BAUD(25000), .DATA_BITS(7), .PARITY(2),
    .STOP_BITS(1), .FIFO_DEPTH(4)
  ) u_b (
    .clk(clk), .rst_n(rst_n),
    .tx_start(b_tx_start), .tx_data(b_tx_data), .tx_busy(b_tx_busy), .txd(b_txd),
    .rxd(b_rxd), .rx_data(b_rx_data), .rx_valid(b_rx_valid), .rx_read(b_rx_read),
    .rx_count(b_rx_count), .rx_frame_err(b_fe), .rx_parity_err(b_pe),
    .rx_overrun(b_ov), .err_clear(b_err_clear)
  );

  // Reference model of instance B's receive side
  logic [6:0] mq[$];
  bit         m_fe, m_pe, m_ov;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One received frame; 'popped' means a pop landed in the same cycle.
  task automatic model_frame(input logic [6:0] d, input bit stop_ok, input bit par_ok,
                             input bit popped);
    if (!stop_ok) begin
      m_fe = 1'b1;
    end else if (!par_ok) begin
      m_pe = 1'b1;
    end else begin
      if (popped && mq.size() != 0) void'(mq.pop_front());
      if (mq.size() < 4) mq.push_back(d);
      else m_ov = 1'b1;
    end
  endtask

  task automatic check_b(input string tag);
    check({tag, ".count"}, 32'(b_rx_count), 32'(mq.size()));
    check({tag, ".valid"}, 32'(b_rx_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) check({tag, ".head"}, 32'(b_rx_data), 32'(mq[0]));
    check({tag, ".frame_err"}, 32'(b_fe), 32'(m_fe));
    check({tag, ".parity_err"}, 32'(b_pe), 32'(m_pe));
    check({tag, ".overrun"}, 32'(b_ov), 32'(m_ov));
  endtask

  task automatic pop_b();
    @(negedge clk); b_rx_read = 1'b1;
    @(negedge clk); b_rx_read = 1'b0;
    if (mq.size() != 0) void'(mq.pop_front());
  endtask

  task automatic clear_b();
    @(negedge clk); b_err_clear = 1'b1;
    @(negedge clk); b_err_clear = 1'b0;
    m_fe = 1'b0; m_pe = 1'b0; m_ov = 1'b0;
  endtask

  // Send through B's own transmitter, looped back into its receiver.
  task automatic send_b(input logic [6:0] d);
    int n;
    b_loop = 1'b1;
    @(negedge clk); b_tx_start = 1'b1; b_tx_data = d;
    @(negedge clk); b_tx_start = 1'b0;
    check("b.tx_busy_rise", 32'(b_tx_busy), 32'd1);
    n = 0;
    while (b_tx_busy && n < 2000) begin
      @(negedge clk); n++;
    end
    check("b.tx_busy_fall", 32'(b_tx_busy), 32'd0);
    repeat (40) @(negedge clk);
    model_frame(d, 1'b1, 1'b1, 1'b0);
  endtask

  // Bit-bang a 7O1 frame onto B's rxd (64 clocks per bit).
  task automatic drive_frame(input logic [6:0] d, input bit par_flip, input bit stop_v);
    logic [9:0] bits;
    bits = {stop_v, (~^d) ^ par_flip, d, 1'b0};
    b_loop = 1'b0;
    for (int i = 0; i < 10; i++) begin
      b_drv = bits[i];
      repeat (64) @(negedge clk);
    end
    b_drv = 1'b1;
    repeat (96) @(negedge clk);
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_bits[$];
    int n;
    bit bad;
    bit seen;
    logic [7:0] a_byte;
    logic [6:0] d;
    logic [6:0] ovb[6];

    a_tx_start = 0; a_tx_data = '0; a_rxd = 1'b1; a_rx_read = 0; a_err_clear = 0;
    b_tx_start = 0; b_tx_data = '0; b_rx_read = 0; b_err_clear = 0;
    b_loop = 1'b0; b_drv = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst.a_txd", 32'(a_txd), 32'd1);
    check("rst.a_tx_busy", 32'(a_tx_busy), 32'd0);
    check("rst.a_rx_valid", 32'(a_rx_valid), 32'd0);
    check("rst.a_rx_count", 32'(a_rx_count), 32'd0);
    check("rst.a_rx_data", 32'(a_rx_data), 32'd0);
    check("rst.a_flags", 32'({a_fe, a_pe, a_ov}), 32'd0);
    check("rst.b_txd", 32'(b_txd), 32'd1);
    check("rst.b_rx_data", 32'(b_rx_data), 32'd0);
    check_b("rst.b");

    @(negedge clk); rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // TX 8N2 with 0xA5 on instance A
    a_byte = 8'hA5;
    exp_bits.push_back(0);
    for (int i = 0; i < 8; i++) exp_bits.push_back(int'(a_byte[i]));
    exp_bits.push_back(1);
    exp_bits.push_back(1);

    a_tx_data = a_byte; a_tx_start = 1'b1;
    @(negedge clk); a_tx_start = 1'b0;
    check("a.busy_on_accept", 32'(a_tx_busy), 32'd1);
    check("a.txd_start", 32'(a_txd), 32'(exp_bits[0]));
    n = 0;
    while (!a_txd && n < 600) begin
      @(negedge clk); n++;
    end
    // Start bit may be shortened by up to DIV-1 clocks.
    check("a.start_len_ok", 32'(n >= 406 && n <= 432), 32'd1);
    repeat (216) @(negedge clk);
    for (int i = 1; i < 11; i++) begin
      check($sformatf("a.bit%0d", i - 1), 32'(a_txd), 32'(exp_bits[i]));
      check($sformatf("a.busy_bit%0d", i - 1), 32'(a_tx_busy), 32'd1);
      if (i == 4) begin
        // A request while busy must be ignored and not queued.
        a_tx_start = 1'b1; a_tx_data = 8'hFF;
        @(negedge clk); a_tx_start = 1'b0; a_tx_data = a_byte;
        if (i < 10) repeat (431) @(negedge clk);
      end else if (i < 10) begin
        repeat (432) @(negedge clk);
      end
    end
    repeat (215) @(negedge clk);
    check("a.busy_last_cycle", 32'(a_tx_busy), 32'd1);
    @(negedge clk);
    check("a.busy_fall", 32'(a_tx_busy), 32'd0);
    check("a.txd_idle", 32'(a_txd), 32'd1);
    bad = 1'b0;
    repeat (500) begin
      @(negedge clk);
      if (a_txd !== 1'b1 || a_tx_busy !== 1'b0) bad = 1'b1;
    end
    check("a.no_queued_frame", 32'(bad), 32'd0);

    // Loopback on B (7O1): directed bytes
    send_b(7'h00); check_b("lb0");
    send_b(7'h7F); check_b("lb1");
    send_b(7'h55); check_b("lb2");
    pop_b(); check_b("lb_pop0");
    pop_b(); check_b("lb_pop1");
    pop_b(); check_b("lb_pop2");

    // Loopback with random bytes
    for (int k = 0; k < 4; k++) begin
      d = 7'($urandom_range(0, 127));
      send_b(d); check_b($sformatf("rnd%0d", k));
      pop_b(); check_b($sformatf("rnd_pop%0d", k));
    end

    // Error frames
    drive_frame(7'h3C, 1'b0, 1'b0);
    model_frame(7'h3C, 1'b0, 1'b1, 1'b0);
    check_b("err_stop");
    d = 7'($urandom_range(0, 127));
    drive_frame(d, 1'b1, 1'b1);
    model_frame(d, 1'b1, 1'b0, 1'b0);
    check_b("err_parity");
    clear_b();
    check_b("err_clear");

    // Glitch: 3 ticks low
    b_loop = 1'b0; b_drv = 1'b0;
    repeat (12) @(negedge clk);
    b_drv = 1'b1;
    repeat (200) @(negedge clk);
    check_b("glitch");

    // Overrun: five frames into a 4-deep FIFO
    for (int k = 0; k < 6; k++) ovb[k] = 7'($urandom_range(0, 127));
    for (int k = 0; k < 5; k++) begin
      drive_frame(ovb[k], 1'b0, 1'b1);
      model_frame(ovb[k], 1'b1, 1'b1, 1'b0);
      check_b($sformatf("ovr%0d", k));
    end
    check("ovr.head_is_first", 32'(b_rx_data), 32'(ovb[0]));
    clear_b();
    check_b("ovr_clear");

    // Push while full with a pop in the same cycle
    seen = 1'b0;
    fork
      drive_frame(ovb[5], 1'b0, 1'b1);
      begin
        for (int w = 0; w < 1200 && !seen; w++) begin
          @(negedge clk);
          if (u_b.rx_push_req) begin
            b_rx_read = 1'b1;
            @(negedge clk);
            b_rx_read = 1'b0;
            seen = 1'b1;
          end
        end
      end
    join
    check("ovr_pop.push_seen", 32'(seen), 32'd1);
    model_frame(ovb[5], 1'b1, 1'b1, 1'b1);
    check_b("ovr_pop");

    // Reset in the middle of a TX frame
    @(negedge clk); a_tx_data = 8'hA5; a_tx_start = 1'b1;
    @(negedge clk); a_tx_start = 1'b0;
    repeat (1000) @(negedge clk);
    check("midrst.a_txd_before", 32'(a_txd), 32'd0);
    check("midrst.b_count_before", 32'(b_rx_count), 32'd4);
    #2 rst_n = 1'b0;
    #1;
    check("midrst.a_txd", 32'(a_txd), 32'd1);
    check("midrst.a_busy", 32'(a_tx_busy), 32'd0);
    check("midrst.b_count", 32'(b_rx_count), 32'd0);
    check("midrst.b_valid", 32'(b_rx_valid), 32'd0);
    check("midrst.b_data", 32'(b_rx_data), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    bad = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (a_txd !== 1'b1 || a_tx_busy !== 1'b0) bad = 1'b1;
    end
    check("midrst.frame_lost", 32'(bad), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
